// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default timing constants for the
// button debouncer bank (25 MHz game_clk defaults).
package debounce_pkg;

  // Per-channel debouncer state.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    RISE_CHK  = 2'd1,
    STABLE_HI = 2'd2,
    FALL_CHK  = 2'd3
  } db_state_t;

  // 10 ms stability window at 25 MHz.
  localparam int DB_CNT_10MS_25M   = 250000;
  // 250 ms hold before the first auto-repeat pulse at 25 MHz.
  localparam int DB_REP_DELAY_25M  = 6250000;
  // 50 ms between subsequent auto-repeat pulses at 25 MHz.
  localparam int DB_REP_PERIOD_25M = 1250000;

  // Larger of two integers; used to size shared timers.
  function automatic int db_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one debouncer channel. Raw input -> SYNC_STAGES-flop
// synchroniser -> 4-state stability FSM with counter -> registered level,
// press and release pulses. Optional auto-repeat timer built only when
// DEBOUNCE_REPEAT_EN is defined; otherwise repeat_pulse is tied to 0.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int CNT_MAX       = DB_CNT_10MS_25M,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = DB_REP_DELAY_25M,
  parameter int REPEAT_PERIOD = DB_REP_PERIOD_25M
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  // Counter only ever reaches CNT_MAX-1, so $clog2(CNT_MAX) bits suffice.
  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_s;

  db_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync_s = sync_reg[SYNC_STAGES-1];

  // FSM, stability counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= STABLE_LO;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  // Next-state logic: a change is accepted only after CNT_MAX consecutive
  // synced samples at the new value; any bounce returns to the old state.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state_reg)
      STABLE_LO: begin
        if (sync_s) begin
          state_next = RISE_CHK;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next = '0;
        end
      end
      RISE_CHK: begin
        if (!sync_s) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = STABLE_HI;
          level_next = 1'b1;
          press_next = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sync_s) begin
          state_next = FALL_CHK;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next = '0;
        end
      end
      FALL_CHK: begin
        if (sync_s) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = STABLE_LO;
          level_next   = 1'b0;
          release_next = 1'b1;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = STABLE_LO;
        cnt_next   = '0;
      end
    endcase
  end

  assign level         = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int REP_W = $clog2(db_max(db_max(REPEAT_DELAY, REPEAT_PERIOD), 2));
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic             rep_first_reg, rep_first_next;
  logic             repeat_reg, repeat_next;

  // Repeat timer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_reg   <= '0;
      rep_first_reg <= 1'b0;
      repeat_reg    <= 1'b0;
    end else begin
      rep_cnt_reg   <= rep_cnt_next;
      rep_first_reg <= rep_first_next;
      repeat_reg    <= repeat_next;
    end
  end

  // Timer runs while the debounced level is high; the first interval is
  // REPEAT_DELAY, later ones REPEAT_PERIOD. The cycle that returns to
  // STABLE_LO clears it without firing. The press cycle sees level_reg=0,
  // so press and repeat cannot coincide.
  always_comb begin
    rep_cnt_next   = rep_cnt_reg;
    rep_first_next = rep_first_reg;
    repeat_next    = 1'b0;
    if (!level_reg || release_next) begin
      rep_cnt_next   = '0;
      rep_first_next = 1'b0;
    end else if (rep_cnt_reg == (rep_first_reg ? PERIOD_LAST : DELAY_LAST)) begin
      repeat_next    = 1'b1;
      rep_cnt_next   = '0;
      rep_first_next = 1'b1;
    end else begin
      rep_cnt_next = rep_cnt_reg + REP_W'(1);
    end
  end

  assign repeat_pulse = repeat_reg;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_bank.sv
// btn_debounce_bank: NUM_CH independent button/switch debouncers in the
// game_clk domain. Define DEBOUNCE_REPEAT_EN to build the auto-repeat timers;
// without it btn_repeat is constant 0.
module btn_debounce_bank
  import debounce_pkg::*;
#(
  parameter int NUM_CH        = 5,
  parameter int CNT_MAX       = DB_CNT_10MS_25M,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = DB_REP_DELAY_25M,
  parameter int REPEAT_PERIOD = DB_REP_PERIOD_25M
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] btn_raw,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_repeat
);

  // One fully independent debouncer per input pin.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      debounce_ch #(
        .CNT_MAX      (CNT_MAX),
        .SYNC_STAGES  (SYNC_STAGES),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_ch (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw          (btn_raw[gi]),
        .level        (btn_level[gi]),
        .press_pulse  (btn_press[gi]),
        .release_pulse(btn_release[gi]),
        .repeat_pulse (btn_repeat[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce_bank.sv
// tb_btn_debounce_bank: scoreboard bench. Expected press/release events are
// queued when raw stimulus is driven and checked every cycle on the falling
// clock edge; repeat pulses follow from the expected press/release times.
module tb_btn_debounce_bank;

  localparam int NUM_CH        = 3;
  localparam int CNT_MAX       = 8;
  localparam int SYNC_STAGES   = 2;
  localparam int REPEAT_DELAY  = 20;
  localparam int REPEAT_PERIOD = 5;
  localparam int LAT           = SYNC_STAGES + CNT_MAX;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] btn_raw = '0;
  logic [NUM_CH-1:0] btn_level;
  logic [NUM_CH-1:0] btn_press;
  logic [NUM_CH-1:0] btn_release;
  logic [NUM_CH-1:0] btn_repeat;

  typedef struct {
    int cyc;
    int ch;
    bit is_press;
  } evt_t;

  evt_t              sb_q[$];
  int                cyc = 0;
  int                vectors = 0;
  int                miscompares = 0;
  logic [NUM_CH-1:0] exp_level = '0;
  int                press_cyc[NUM_CH];

  btn_debounce_bank #(
    .NUM_CH       (NUM_CH),
    .CNT_MAX      (CNT_MAX),
    .SYNC_STAGES  (SYNC_STAGES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Advance n falling edges, then settle 2 time units before driving.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic expect_evt(input int ch, input bit p);
    evt_t e;
    e.cyc      = cyc + LAT;
    e.ch       = ch;
    e.is_press = p;
    sb_q.push_back(e);
  endtask

  // Per-cycle monitor: pop this cycle's expected events and compare.
  always @(negedge clk) begin
    logic [NUM_CH-1:0] ep;
    logic [NUM_CH-1:0] er;
    logic [NUM_CH-1:0] erp;
    int d;
    if (rst_n) begin
      ep  = '0;
      er  = '0;
      erp = '0;
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].cyc == cyc) begin
          if (sb_q[i].is_press) ep[sb_q[i].ch] = 1'b1;
          else                  er[sb_q[i].ch] = 1'b1;
          $display("cycle %0d ch%0d %s", cyc, sb_q[i].ch, sb_q[i].is_press ? "press" : "release");
          sb_q.delete(i);
        end
      end
`ifdef DEBOUNCE_REPEAT_EN
      for (int c = 0; c < NUM_CH; c++) begin
        d = cyc - press_cyc[c];
        if (exp_level[c] && !er[c] && d >= REPEAT_DELAY &&
            ((d - REPEAT_DELAY) % REPEAT_PERIOD) == 0)
          erp[c] = 1'b1;
      end
`endif
      check_val("press", 32'(btn_press), 32'(ep));
      check_val("release", 32'(btn_release), 32'(er));
      check_val("repeat", 32'(btn_repeat), 32'(erp));
      for (int c = 0; c < NUM_CH; c++) begin
        if (ep[c]) begin
          exp_level[c] = 1'b1;
          press_cyc[c] = cyc;
        end
        if (er[c]) exp_level[c] = 1'b0;
      end
      check_val("level", 32'(btn_level), 32'(exp_level));
    end
  end

  initial begin
    for (int c = 0; c < NUM_CH; c++) press_cyc[c] = 0;

    // Reset state
    tick(3);
    check_val("rst_level", 32'(btn_level), 32'd0);
    check_val("rst_press", 32'(btn_press), 32'd0);
    check_val("rst_release", 32'(btn_release), 32'd0);
    check_val("rst_repeat", 32'(btn_repeat), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Clean press on channel 0
    btn_raw[0] = 1'b1;
    expect_evt(0, 1'b1);
    tick(15);

    // Bounce on channel 1: 3-cycle toggles, then a steady high
    btn_raw[1] = 1'b1; tick(3);
    btn_raw[1] = 1'b0; tick(3);
    btn_raw[1] = 1'b1; tick(3);
    btn_raw[1] = 1'b0; tick(3);
    btn_raw[1] = 1'b1;
    expect_evt(1, 1'b1);
    tick(15);

    // Clean releases
    btn_raw[0] = 1'b0;
    expect_evt(0, 1'b0);
    tick(15);
    btn_raw[1] = 1'b0;
    expect_evt(1, 1'b0);
    tick(15);

    // Simultaneous press and release on all channels
    btn_raw = '1;
    for (int c = 0; c < NUM_CH; c++) expect_evt(c, 1'b1);
    tick(15);
    btn_raw = '0;
    for (int c = 0; c < NUM_CH; c++) expect_evt(c, 1'b0);
    tick(15);

    // Level held 40 cycles after press: repeats at +20..+35, none at release
    btn_raw[0] = 1'b1;
    expect_evt(0, 1'b1);
    tick(40);
    btn_raw[0] = 1'b0;
    expect_evt(0, 1'b0);
    tick(15);

    // Reset mid-count: ch2 already high, ch0 at its 5th count cycle
    btn_raw[2] = 1'b1;
    expect_evt(2, 1'b1);
    tick(15);
    btn_raw[0] = 1'b1;
    tick(7);
    rst_n = 1'b0;
    #1;
    check_val("async_level", 32'(btn_level), 32'd0);
    check_val("async_press", 32'(btn_press), 32'd0);
    check_val("async_release", 32'(btn_release), 32'd0);
    check_val("async_repeat", 32'(btn_repeat), 32'd0);
    sb_q.delete();
    exp_level = '0;
    tick(3);
    rst_n = 1'b1;
    expect_evt(0, 1'b1);
    expect_evt(2, 1'b1);
    tick(25);
    btn_raw = '0;
    expect_evt(0, 1'b0);
    expect_evt(2, 1'b0);
    tick(15);

    // Every queued event must have been consumed
    check_val("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
